// File: rtl/gpio_rr_scheduler.sv
// Round-robin owner of a shared GPIO output bank: each grant drives the bank for a
// requested number of cycles, followed by one oe-low turnaround cycle.
module gpio_rr_scheduler #(
    parameter int                NUM_REQ  = 4,
    parameter int                GPIO_W   = 8,
    parameter int                HOLD_W   = 8,
    parameter logic [GPIO_W-1:0] IDLE_VAL = '0
) (
    input  logic                       clk_i,
    input  logic                       rst_i,
    input  logic [NUM_REQ-1:0]         req_i,
    input  logic [NUM_REQ*GPIO_W-1:0]  data_i,
    input  logic [NUM_REQ*HOLD_W-1:0]  hold_i,
    output logic [NUM_REQ-1:0]         gnt_o,
    output logic [NUM_REQ-1:0]         done_o,
    output logic [GPIO_W-1:0]          gpio_o,
    output logic                       gpio_oe_o,
    output logic                       busy_o
);

    localparam int PTR_W = $clog2(NUM_REQ);

    localparam logic [1:0] S_IDLE  = 2'd0;
    localparam logic [1:0] S_DRIVE = 2'd1;
    localparam logic [1:0] S_GAP   = 2'd2;

    logic [1:0]        state;
    logic [PTR_W-1:0]  ptr;
    logic [PTR_W-1:0]  cur;
    logic [HOLD_W-1:0] cnt;

    logic              found;
    logic [PTR_W-1:0]  win;
    logic [PTR_W-1:0]  cand;
    logic [PTR_W-1:0]  nxt_ptr;
    logic [GPIO_W-1:0] win_data;
    logic [HOLD_W-1:0] win_hold;
    int                idx;

    // First asserted request at or above ptr, wrapping around.
    always_comb begin
        found = 1'b0;
        win   = '0;
        cand  = '0;
        idx   = 0;
        for (int i = 0; i < NUM_REQ; i++) begin
            idx  = (int'(ptr) + i) % NUM_REQ;
            cand = PTR_W'(idx);
            if (!found && req_i[cand]) begin
                found = 1'b1;
                win   = cand;
            end
        end
    end

    assign nxt_ptr  = PTR_W'((int'(win) + 1) % NUM_REQ);
    assign win_data = data_i[int'(win)*GPIO_W +: GPIO_W];
    assign win_hold = hold_i[int'(win)*HOLD_W +: HOLD_W];
    assign busy_o   = (state != S_IDLE);

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state     <= S_IDLE;
            ptr       <= '0;
            cur       <= '0;
            cnt       <= '0;
            gnt_o     <= '0;
            done_o    <= '0;
            gpio_o    <= IDLE_VAL;
            gpio_oe_o <= 1'b0;
        end else begin
            gnt_o  <= '0;
            done_o <= '0;
            case (state)
                S_DRIVE: begin
                    if (cnt != '0) begin
                        cnt <= cnt - HOLD_W'(1);
                    end else begin
                        state     <= S_GAP;
                        gpio_oe_o <= 1'b0;
                        gpio_o    <= IDLE_VAL;
                        done_o    <= NUM_REQ'(1) << cur;
                    end
                end
                default: begin
                    // IDLE and GAP both arbitrate; GAP falls back to IDLE when nobody asks.
                    if (found) begin
                        state     <= S_DRIVE;
                        gnt_o     <= NUM_REQ'(1) << win;
                        gpio_o    <= win_data;
                        gpio_oe_o <= 1'b1;
                        cnt       <= (win_hold == '0) ? '0 : win_hold - HOLD_W'(1);
                        cur       <= win;
                        ptr       <= nxt_ptr;
                    end else begin
                        state <= S_IDLE;
                    end
                end
            endcase
        end
    end

endmodule

// File: tb/tb_gpio_rr_scheduler.sv
// Bench for gpio_rr_scheduler: directed literal checks plus random traffic compared
// every cycle against a burst-schedule model.
module tb_gpio_rr_scheduler;

    localparam int N = 4;
    localparam int G = 8;
    localparam int H = 8;

    logic           clk = 1'b0;
    logic           rst;
    logic [N-1:0]   req;
    logic [N*G-1:0] data;
    logic [N*H-1:0] hold;
    logic [N-1:0]   gnt_o, done_o;
    logic [G-1:0]   gpio_o;
    logic           gpio_oe_o, busy_o;

    always #5 clk = ~clk;

    gpio_rr_scheduler #(.NUM_REQ(N), .GPIO_W(G), .HOLD_W(H), .IDLE_VAL('0)) dut (
        .clk_i(clk), .rst_i(rst), .req_i(req), .data_i(data), .hold_i(hold),
        .gnt_o(gnt_o), .done_o(done_o), .gpio_o(gpio_o), .gpio_oe_o(gpio_oe_o), .busy_o(busy_o)
    );

    int n_chk = 0;
    int n_err = 0;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
        end
    endtask

    // Model: a granted burst is a list of per-cycle output vectors queued ahead;
    // a new grant can only be taken when nothing is queued (idle or last GAP cycle).
    typedef struct packed {
        logic [N-1:0] gnt;
        logic [N-1:0] done;
        logic [G-1:0] gpio;
        logic         oe;
        logic         busy;
    } exp_t;

    exp_t q[$];
    exp_t e;
    exp_t mx;
    int   m_ptr, mw, mh;
    logic chk_en = 1'b0;

    always @(posedge clk) begin
        if (rst) begin
            q.delete();
            m_ptr = 0;
            e     = '0;
        end else begin
            if (q.size() == 0 && req != '0) begin
                mw = -1;
                for (int i = 0; i < N; i++)
                    if (mw < 0 && req[(m_ptr + i) % N]) mw = (m_ptr + i) % N;
                mh = int'(hold[mw*H +: H]);
                if (mh == 0) mh = 1;
                for (int i = 0; i < mh; i++) begin
                    mx.gnt  = (i == 0) ? (N'(1) << mw) : '0;
                    mx.done = '0;
                    mx.gpio = data[mw*G +: G];
                    mx.oe   = 1'b1;
                    mx.busy = 1'b1;
                    q.push_back(mx);
                end
                mx.gnt  = '0;
                mx.done = N'(1) << mw;
                mx.gpio = '0;
                mx.oe   = 1'b0;
                mx.busy = 1'b1;
                q.push_back(mx);
                m_ptr = (mw + 1) % N;
            end
            if (q.size() != 0) e = q.pop_front();
            else               e = '0;
        end
    end

    always @(negedge clk) begin
        if (chk_en) begin
            chk("cyc_gnt",  32'(gnt_o),     32'(e.gnt));
            chk("cyc_done", 32'(done_o),    32'(e.done));
            chk("cyc_gpio", 32'(gpio_o),    32'(e.gpio));
            chk("cyc_oe",   32'(gpio_oe_o), 32'(e.oe));
            chk("cyc_busy", 32'(busy_o),    32'(e.busy));
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic set_src(input int k, input logic [G-1:0] d, input logic [H-1:0] h);
        data[k*G +: G] = d;
        hold[k*H +: H] = h;
    endtask

    function automatic int oh2i(input logic [N-1:0] v);
        for (int i = 0; i < N; i++) if (v[i]) return i;
        return -1;
    endfunction

    int order[5];
    int exp3[5] = '{0, 1, 2, 3, 0};
    int ng;

    initial begin
        rst = 1'b1; req = '0; data = '0; hold = '0;
        step();
        chk_en = 1'b1;
        step();
        chk("rst_oe",   32'(gpio_oe_o), 0);
        chk("rst_gpio", 32'(gpio_o),    0);
        chk("rst_busy", 32'(busy_o),    0);
        chk("rst_gnt",  32'(gnt_o),     0);
        chk("rst_done", 32'(done_o),    0);
        rst = 1'b0;

        // single request, hold 3
        set_src(0, 8'hA5, 8'd3); req = 4'b0001;
        step();
        chk("t1_gnt", 32'(gnt_o), 32'h1); chk("t1_oe1", 32'(gpio_oe_o), 1); chk("t1_gpio", 32'(gpio_o), 32'hA5);
        req = '0;
        step(); step();
        chk("t1_oe3", 32'(gpio_oe_o), 1); chk("t1_gpio3", 32'(gpio_o), 32'hA5);
        step();
        chk("t1_done", 32'(done_o), 32'h1); chk("t1_oe4", 32'(gpio_oe_o), 0);
        step();
        chk("t1_idle", 32'(busy_o), 0);

        // hold 0 behaves as 1
        set_src(2, 8'h3C, 8'd0); req = 4'b0100;
        step();
        chk("t2_gnt", 32'(gnt_o), 32'h4); chk("t2_gpio", 32'(gpio_o), 32'h3C);
        req = '0;
        step();
        chk("t2_oe", 32'(gpio_oe_o), 0); chk("t2_done", 32'(done_o), 32'h4);
        step();
        chk("t2_idle", 32'(busy_o), 0);

        // all four from reset, hold 1
        rst = 1'b1; step(); rst = 1'b0;
        for (int k = 0; k < N; k++) set_src(k, 8'(8'h10 + k), 8'd1);
        req = 4'hF;
        ng = 0;
        for (int i = 0; i < 5; i++) order[i] = -1;
        for (int c = 0; c < 12; c++) begin
            step();
            if (gnt_o != '0 && ng < 5) begin order[ng] = oh2i(gnt_o); ng++; end
        end
        for (int i = 0; i < 5; i++) chk("t3_order", 32'(order[i]), 32'(exp3[i]));
        req = '0;
        step(); step(); step();

        // wrap: bring ptr to 3, then 1001 -> 3, 0, 3
        req = 4'b0100;
        step(); req = '0; step(); step();
        req = 4'b1001;
        step(); chk("t4_g3a", 32'(gnt_o), 32'h8);
        step();
        step(); chk("t4_g0",  32'(gnt_o), 32'h1);
        step();
        step(); chk("t4_g3b", 32'(gnt_o), 32'h8);
        req = '0;
        step(); step(); step();

        // reset mid-burst
        set_src(2, 8'h5A, 8'd10); req = 4'b0100;
        step(); req = '0; step();
        rst = 1'b1;
        step();
        chk("t5_oe", 32'(gpio_oe_o), 0); chk("t5_gpio", 32'(gpio_o), 0);
        chk("t5_done", 32'(done_o), 0);  chk("t5_busy", 32'(busy_o), 0);
        rst = 1'b0;
        step();
        chk("t5_nodone", 32'(done_o), 0);
        set_src(0, 8'h01, 8'd1); set_src(3, 8'h08, 8'd1); req = 4'b1001;
        step(); chk("t5_ptr0", 32'(gnt_o), 32'h1);
        req = '0;
        step(); step(); step();

        // back-to-back through GAP
        set_src(1, 8'h11, 8'd2); req = 4'b0010;
        step(); chk("t6_g1", 32'(gnt_o), 32'h2);
        step();
        set_src(2, 8'h22, 8'd1); req = 4'b0110;
        step(); chk("t6_gap_oe", 32'(gpio_oe_o), 0); chk("t6_done1", 32'(done_o), 32'h2);
        step(); chk("t6_g2", 32'(gnt_o), 32'h4); chk("t6_oe", 32'(gpio_oe_o), 1); chk("t6_gpio", 32'(gpio_o), 32'h22);
        req = 4'b0010;
        step();
        step(); chk("t6_g1b", 32'(gnt_o), 32'h2);
        req = '0;
        step(); step(); step(); step();

        // random traffic
        for (int c = 0; c < 3000; c++) begin
            step();
            if (rst) rst = 1'b0;
            else if ($urandom_range(0, 399) == 0) rst = 1'b1;
            for (int k = 0; k < N; k++) begin
                if (req[k] && gnt_o[k]) begin
                    if ($urandom_range(0, 1) == 1) req[k] = 1'b0;
                end else if (!req[k] && $urandom_range(0, 3) == 0) begin
                    req[k] = 1'b1;
                    set_src(k, 8'($urandom),
                            ($urandom_range(0, 40) == 0) ? 8'hFF : 8'($urandom_range(0, 6)));
                end
            end
        end

        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end

endmodule
